// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin arbiter/sequencer sharing one tinyalu among N_REQ requesters
module alu_req_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*4-1:0]       req_op,
  input  logic [N_REQ*8-1:0]       req_a,
  input  logic [N_REQ*8-1:0]       req_b,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [15:0]              rsp_result,
  output logic                     rsp_error,
  output logic                     rsp_timeout,
  output logic                     alu_start,
  output logic [3:0]               alu_op,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic                     alu_done,
  input  logic [15:0]              alu_result,
  input  logic                     alu_error,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);
  localparam int GW = $clog2(N_REQ);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_NOP1 = 4'h5;
  localparam logic [3:0] OP_RST  = 4'h7;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [GW-1:0] last_grant, pick, idx;
  logic          any, accept, nop_op, err_nx, to_nx;
  logic [3:0]    op_q;
  logic [7:0]    a_q, b_q;
  logic [15:0]   res_nx;
  logic [WW-1:0] wdog;
  // round-robin search from last_grant+1; descending loop so the nearest requester wins
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N_REQ);
      if (req_valid[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end
  // accept only in IDLE and never while reset is asserted, so no handshake can be lost
  assign req_ready = (state == IDLE && !reset_n && any) ? N_REQ'(1) << pick : '0;
  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = state == RESP ? N_REQ'(1) << grant_id : '0;
  assign busy      = state != IDLE;
  assign nop_op    = op_q == OP_NOP || op_q == OP_NOP1 || op_q == OP_RST;
  // ALU drive plus next-state and response-flag selection
  always_comb begin
    state_nx  = state;
    res_nx    = rsp_result;
    err_nx    = rsp_error;
    to_nx     = rsp_timeout;
    alu_start = state == WAIT || (state == ISSUE && !nop_op && !alu_error);
    alu_op    = (state == ISSUE || state == WAIT) ? op_q : OP_NOP;
    alu_a     = (state == ISSUE || state == WAIT) ? a_q : 8'h00;
    alu_b     = (state == ISSUE || state == WAIT) ? b_q : 8'h00;
    case (state)
      IDLE: if (accept) begin
        state_nx = ISSUE;
        res_nx   = '0;
        err_nx   = 1'b0;
        to_nx    = 1'b0;
      end
      ISSUE: begin
        state_nx = alu_start ? WAIT : RESP;
        err_nx   = !nop_op && alu_error;
      end
      WAIT: if (alu_done) begin
        state_nx = RESP;
        res_nx   = alu_result;
      end else if (TIMEOUT != 0 && wdog == WLIM) begin
        state_nx = RESP;
        to_nx    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, operand latch, watchdog and response registers
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state       <= IDLE;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      grant_id    <= '0;
      last_grant  <= GW'(N_REQ - 1);
      wdog        <= '0;
      op_q        <= OP_NOP;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state       <= state_nx;
      rsp_result  <= res_nx;
      rsp_error   <= err_nx;
      rsp_timeout <= to_nx;
      wdog        <= state == WAIT ? wdog + 1'b1 : '0;
      if (accept) begin
        grant_id <= pick;
        op_q     <= req_op[4*int'(pick) +: 4];
        a_q      <= req_a[8*int'(pick) +: 8];
        b_q      <= req_b[8*int'(pick) +: 8];
      end
      if (state == RESP) last_grant <= grant_id;
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: randomized and directed checks of alu_req_arbiter against a behavioural model
module tb_alu_req_arbiter;
  localparam int N  = 2;
  localparam int TO = 15;
  logic        clk = 1'b0, reset_n = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid;
  logic [7:0]  req_op = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [15:0] rsp_result, alu_result = '0;
  logic        rsp_error, rsp_timeout, alu_start, alu_done = 1'b0, alu_error, busy;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic [0:0]  grant_id;
  bit          hang = 1'b0;
  int          cnt = 0, checks = 0, passed = 0, last_g = N - 1;

  always #5 clk = ~clk;

  alu_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
    .busy(busy), .grant_id(grant_id));

  function automatic bit legal(logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7};
  endfunction
  function automatic bit nopish(logic [3:0] op);
    return op inside {4'h0, 4'h5, 4'h7};
  endfunction
  function automatic logic [15:0] calc(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      4'h1: return 16'(a) + 16'(b);
      4'h2: return 16'(a & b);
      4'h3: return 16'(a ^ b);
      4'h4: return 16'(a) * 16'(b);
      default: return 16'h0;
    endcase
  endfunction
  function automatic int alu_lat(logic [3:0] op);
    return op == 4'h4 ? 3 : 1;
  endfunction
  function automatic int rr_pick(logic [1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  function automatic int exp_lat(logic [3:0] op, bit h);
    if (!legal(op) || nopish(op)) return 2;
    return h ? 2 + TO : 2 + alu_lat(op);
  endfunction
  function automatic int exp_starts(logic [3:0] op, bit h);
    if (!legal(op) || nopish(op)) return 0;
    return h ? TO + 1 : 1 + alu_lat(op);
  endfunction

  assign alu_error = !legal(alu_op);

  // ALU stand-in: raises done alu_lat cycles after start first seen, or never when hang is set
  always @(posedge clk) begin
    if (alu_start && !alu_done && !hang && cnt == alu_lat(alu_op) - 1) begin
      alu_done   <= 1'b1;
      alu_result <= calc(alu_op, alu_a, alu_b);
      cnt        <= 0;
    end else begin
      alu_done <= 1'b0;
      cnt      <= (alu_start && !alu_done) ? cnt + 1 : 0;
    end
  end

  task automatic run_op(input logic [1:0] v, input logic [7:0] op_v, input logic [15:0] a_v,
                        input logic [15:0] b_v, input bit hold, output logic [1:0] rdy,
                        output int lat, output logic [1:0] rv, output logic [15:0] res,
                        output logic err, output logic to, output int ns, output int bad);
    int g;
    @(negedge clk);
    req_valid = v; req_op = op_v; req_a = a_v; req_b = b_v;
    #1 rdy = req_ready;
    g = rdy[1] ? 1 : 0;
    lat = -1; rv = '0; res = 'x; err = 1'bx; to = 1'bx; ns = 0; bad = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin
        req_valid = 2'($urandom); req_op = 8'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
      end
      #1;
      if (req_ready !== 2'b00) bad++;
      if (alu_start === 1'b1) begin
        ns++;
        if (alu_op !== op_v[4*g +: 4] || alu_a !== a_v[8*g +: 8] || alu_b !== b_v[8*g +: 8]) bad++;
      end
      if (rsp_valid !== 2'b00) begin
        lat = k; rv = rsp_valid; res = rsp_result; err = rsp_error; to = rsp_timeout;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1; req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready); else passed++;
    checks++; if ({busy, alu_start, rsp_valid} !== 4'b0) $display("FAIL reset_ctrl: got busy=%b start=%b rv=%b want 0", busy, alu_start, rsp_valid); else passed++;
    checks++; if ({alu_op, alu_a, alu_b} !== 20'h0) $display("FAIL reset_alu: got op=%h a=%h b=%h want 0", alu_op, alu_a, alu_b); else passed++;
    checks++; if ({rsp_result, rsp_error, rsp_timeout, grant_id} !== 19'h0) $display("FAIL reset_rsp: got res=%h e=%b t=%b g=%b want 0", rsp_result, rsp_error, rsp_timeout, grant_id); else passed++;
    reset_n = 1'b0; req_valid = 2'b00;
    last_g = N - 1;
  endtask

  task automatic test_add;
    logic [1:0] rdy, rv; int lat, ns, bad; logic [15:0] res; logic err, to;
    run_op(2'b01, 8'h01, 16'h0012, 16'h0034, 1'b0, rdy, lat, rv, res, err, to, ns, bad);
    checks++; if (rdy !== 2'b01) $display("FAIL add_ready: got %b want 01", rdy); else passed++;
    checks++; if (lat !== 3 || rv !== 2'b01) $display("FAIL add_latency: got lat=%0d rv=%b want 3/01", lat, rv); else passed++;
    checks++; if ({res, err, to} !== {16'h0046, 2'b00}) $display("FAIL add_result: got %h e=%b t=%b want 0046/0/0", res, err, to); else passed++;
    checks++; if (ns !== 2 || bad !== 0) $display("FAIL add_alu_drive: got starts=%0d bad=%0d want 2/0", ns, bad); else passed++;
    last_g = 0;
  endtask

  task automatic test_back_to_back;
    logic [1:0] rdy, rv; int lat, ns, bad, e; logic [15:0] res; logic err, to;
    for (int i = 0; i < 4; i++) begin
      e = rr_pick(2'b11, last_g);
      run_op(2'b11, {4'h2, 4'h4}, {8'hF0, 8'h03}, {8'h3C, 8'h05}, 1'b1, rdy, lat, rv, res, err, to, ns, bad);
      checks++; if (rdy !== 2'(1 << e) || rv !== 2'(1 << e)) $display("FAIL b2b_grant%0d: got rdy=%b rv=%b want %b", i, rdy, rv, 2'(1 << e)); else passed++;
      checks++; if (res !== (e == 0 ? 16'h000F : 16'h0030) || lat !== (e == 0 ? 5 : 3)) $display("FAIL b2b_result%0d: got %h lat=%0d want %h lat=%0d", i, res, lat, e == 0 ? 16'h000F : 16'h0030, e == 0 ? 5 : 3); else passed++;
      last_g = e;
    end
  endtask

  task automatic test_illegal;
    logic [1:0] rdy, rv; int lat, ns, bad; logic [15:0] res; logic err, to;
    run_op(2'b10, 8'h60, 16'h1111, 16'h2222, 1'b0, rdy, lat, rv, res, err, to, ns, bad);
    checks++; if (rdy !== 2'b10 || rv !== 2'b10 || lat !== 2) $display("FAIL illegal_timing: got rdy=%b rv=%b lat=%0d want 10/10/2", rdy, rv, lat); else passed++;
    checks++; if ({res, err, to, 8'(ns)} !== {16'h0, 2'b10, 8'd0}) $display("FAIL illegal_rsp: got res=%h e=%b t=%b starts=%0d want 0/1/0/0", res, err, to, ns); else passed++;
    last_g = 1;
  endtask

  task automatic test_nop;
    logic [1:0] rdy, rv; int lat, ns, bad; logic [15:0] res; logic err, to;
    run_op(2'b01, 8'h00, 16'h00AA, 16'h0055, 1'b0, rdy, lat, rv, res, err, to, ns, bad);
    checks++; if (rdy !== 2'b01 || rv !== 2'b01 || lat !== 2) $display("FAIL nop_timing: got rdy=%b rv=%b lat=%0d want 01/01/2", rdy, rv, lat); else passed++;
    checks++; if ({res, err, to, 8'(ns)} !== 26'h0) $display("FAIL nop_rsp: got res=%h e=%b t=%b starts=%0d want all 0", res, err, to, ns); else passed++;
    last_g = 0;
  endtask

  task automatic test_timeout;
    logic [1:0] rdy, rv; int lat, ns, bad, e; logic [15:0] res; logic err, to;
    hang = 1'b1;
    run_op(2'b01, 8'h01, 16'h0007, 16'h0008, 1'b0, rdy, lat, rv, res, err, to, ns, bad);
    hang = 1'b0;
    checks++; if (lat !== 2 + TO || rv !== 2'b01) $display("FAIL timeout_latency: got lat=%0d rv=%b want %0d/01", lat, rv, 2 + TO); else passed++;
    checks++; if ({res, err, to} !== {16'h0, 2'b01} || ns !== TO + 1) $display("FAIL timeout_rsp: got res=%h e=%b t=%b starts=%0d want 0/0/1/%0d", res, err, to, ns, TO + 1); else passed++;
    last_g = 0;
    e = rr_pick(2'b11, last_g);
    run_op(2'b11, 8'h31, 16'h0F0F, 16'h3333, 1'b0, rdy, lat, rv, res, err, to, ns, bad);
    checks++; if (rdy !== 2'(1 << e) || res !== 16'h003C || lat !== 3) $display("FAIL timeout_next: got rdy=%b res=%h lat=%0d want %b/003C/3", rdy, res, lat, 2'(1 << e)); else passed++;
    last_g = e;
  endtask

  task automatic test_random;
    logic [1:0] rdy, rv, v; int lat, ns, bad, e; logic [15:0] res, a, b; logic err, to;
    logic [7:0] ops; logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3)); ops = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
      e = rr_pick(v, last_g);
      op = ops[4*e +: 4];
      run_op(v, ops, a, b, 1'($urandom), rdy, lat, rv, res, err, to, ns, bad);
      checks++;
      if (rdy !== 2'(1 << e) || rv !== 2'(1 << e) || lat !== exp_lat(op, 1'b0) || ns !== exp_starts(op, 1'b0) || bad !== 0)
        $display("FAIL rand%0d_ctrl: op=%h got rdy=%b rv=%b lat=%0d starts=%0d bad=%0d want grant %0d lat=%0d starts=%0d", i, op, rdy, rv, lat, ns, bad, e, exp_lat(op, 1'b0), exp_starts(op, 1'b0));
      else passed++;
      checks++;
      if (res !== calc(op, a[8*e +: 8], b[8*e +: 8]) || err !== !legal(op) || to !== 1'b0)
        $display("FAIL rand%0d_rsp: op=%h got res=%h e=%b t=%b want %h/%b/0", i, op, res, err, to, calc(op, a[8*e +: 8], b[8*e +: 8]), !legal(op));
      else passed++;
      last_g = e;
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] rdy, rv; int lat, ns, bad, pulses; logic [15:0] res; logic err, to;
    run_op(2'b01, 8'h01, 16'h0001, 16'h0002, 1'b0, rdy, lat, rv, res, err, to, ns, bad);
    last_g = 0;
    @(negedge clk);
    req_valid = 2'b10; req_op = 8'h40; req_a = 16'h0700; req_b = 16'h0900;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || alu_start !== 1'b1) $display("FAIL midreset_setup: got busy=%b start=%b want 1/1", busy, alu_start); else passed++;
    reset_n = 1'b1;
    pulses = 0;
    @(negedge clk);
    #1;
    checks++; if ({busy, alu_start, rsp_valid, req_ready} !== 6'h0) $display("FAIL midreset_ctrl: got busy=%b start=%b rv=%b rdy=%b want 0", busy, alu_start, rsp_valid, req_ready); else passed++;
    checks++; if ({alu_op, alu_a, alu_b, rsp_result, rsp_error, rsp_timeout, grant_id} !== 39'h0) $display("FAIL midreset_out: got op=%h a=%h b=%h res=%h e=%b t=%b g=%b want 0", alu_op, alu_a, alu_b, rsp_result, rsp_error, rsp_timeout, grant_id); else passed++;
    repeat (2) begin @(negedge clk); if (rsp_valid !== 2'b00) pulses++; end
    reset_n = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid !== 2'b00) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL midreset_norsp: got %0d pulses want 0", pulses); else passed++;
    last_g = N - 1;
    run_op(2'b11, 8'h33, 16'h0505, 16'h0303, 1'b0, rdy, lat, rv, res, err, to, ns, bad);
    checks++; if (rdy !== 2'(1 << rr_pick(2'b11, last_g)) || res !== 16'h0006) $display("FAIL midreset_first_grant: got rdy=%b res=%h want %b/0006", rdy, res, 2'(1 << rr_pick(2'b11, last_g))); else passed++;
    last_g = rr_pick(2'b11, last_g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_illegal;
    test_nop;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
